// File: rtl/case_select_monitor.sv
// case_select_monitor: registered table-driven case decoder with unique / unique0 / priority
// violation checking, sticky flags and saturating violation counters.
// Ports:
//   clk, rst_n                                   clock, async active-low reset
//   cfg_we, cfg_idx, cfg_en, cfg_key, cfg_data   entry table write port
//   in_valid, in_sel                             lookup request (one per cycle, no back-pressure)
//   clr                                          synchronous clear of counters and sticky flags
//   out_valid, out_data, out_hit, out_idx        lookup result, one cycle after in_valid
//   viol_none, viol_multi                        per-result violation pulses
//   none_cnt, multi_cnt                          saturating violation counts
//   sticky_none, sticky_multi                    sticky violation flags
module case_select_monitor #(
  parameter int SEL_W = 2,
  parameter int DATA_W = 4,
  parameter int ENTRIES = 4,
  parameter int MODE = 0,
  parameter int CNT_W = 8,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = '0,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic              cfg_en,
  input  logic [SEL_W-1:0]  cfg_key,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              in_valid,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_hit,
  output logic [IW-1:0]     out_idx,
  output logic              viol_none,
  output logic              viol_multi,
  output logic [CNT_W-1:0]  none_cnt,
  output logic [CNT_W-1:0]  multi_cnt,
  output logic              sticky_none,
  output logic              sticky_multi
);

  // Elaboration-time parameter checks.
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("case_select_monitor: MODE must be 0 (unique), 1 (unique0) or 2 (priority)");
  end
  if (ENTRIES < 2) begin : g_bad_entries
    $error("case_select_monitor: ENTRIES must be at least 2");
  end

  logic              tab_en   [ENTRIES];
  logic [SEL_W-1:0]  tab_key  [ENTRIES];
  logic [DATA_W-1:0] tab_data [ENTRIES];

  // Only non-power-of-two tables can see an out-of-range index.
  logic idx_ok;
  if (ENTRIES == (1 << IW)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (cfg_idx < IW'(ENTRIES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tab_en[i]   <= 1'b0;
        tab_key[i]  <= '0;
        tab_data[i] <= '0;
      end
    end else if (cfg_we && idx_ok) begin
      tab_en[cfg_idx]   <= cfg_en;
      tab_key[cfg_idx]  <= cfg_key;
      tab_data[cfg_idx] <= cfg_data;
    end
  end

  // Scan from the highest index down so the lowest matching index is the
  // one left selected; a second hit along the way flags a multi-match.
  logic              hit_c;
  logic              multi_c;
  logic [IW-1:0]     idx_c;
  logic [DATA_W-1:0] data_c;

  always_comb begin
    hit_c   = 1'b0;
    multi_c = 1'b0;
    idx_c   = '0;
    data_c  = DEFAULT_DATA;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tab_en[i] && (tab_key[i] == in_sel)) begin
        if (hit_c) multi_c = 1'b1;
        hit_c  = 1'b1;
        idx_c  = IW'(i);
        data_c = tab_data[i];
      end
    end
  end

  // unique0 tolerates no-match, priority tolerates multi-match.
  logic vn_c;
  logic vm_c;
  assign vn_c = in_valid && !hit_c  && (MODE != 1);
  assign vm_c = in_valid && multi_c && (MODE != 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= DEFAULT_DATA;
      out_hit      <= 1'b0;
      out_idx      <= '0;
      viol_none    <= 1'b0;
      viol_multi   <= 1'b0;
      none_cnt     <= '0;
      multi_cnt    <= '0;
      sticky_none  <= 1'b0;
      sticky_multi <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      viol_none  <= vn_c;
      viol_multi <= vm_c;
      if (in_valid) begin
        out_data <= data_c;
        out_hit  <= hit_c;
        out_idx  <= idx_c;
      end
      // clr wins over a coincident violation; the pulse itself still goes out.
      if (clr) begin
        none_cnt     <= '0;
        multi_cnt    <= '0;
        sticky_none  <= 1'b0;
        sticky_multi <= 1'b0;
      end else begin
        if (vn_c && (none_cnt != '1))  none_cnt  <= none_cnt + 1'b1;
        if (vm_c && (multi_cnt != '1)) multi_cnt <= multi_cnt + 1'b1;
        if (vn_c) sticky_none  <= 1'b1;
        if (vm_c) sticky_multi <= 1'b1;
      end
    end
  end

endmodule
